serial_addsub: RTL
==================

# serial_addsub

Digit-serial, parametrised signed adder/subtractor: the multi-cycle successor to the team's 8-bit combinational adder with opcode, carry and overflow. It accepts one operation per start handshake, processes `DIGIT` bits per clock from LSB to MSB, and then presents a registered result with carry, overflow, zero and negative flags. It sits beside the datapath where area matters more than latency, and the control FSM owns all handshaking.

## Interface
- `WIDTH`, 16: operand and result width in bits; must be a multiple of `DIGIT`.
- `DIGIT`, 4: bits processed per cycle; `N = WIDTH/DIGIT` digit cycles per operation; `N = 1` is legal.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request; accepted on a rising edge where `start && ready`.
- `a` in WIDTH: signed operand A; sampled only at acceptance.
- `b` in WIDTH: signed operand B; sampled only at acceptance.
- `opcode` in 1: 0 = A+B, 1 = A−B; sampled only at acceptance.
- `ready` out 1: high in IDLE and DONE.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse marking the result update.
- `sum` out WIDTH: registered result; held until the next completion.
- `carry` out 1: carry out of the MSB; for subtraction, 1 = no borrow.
- `overflow` out 1: signed overflow.
- `zero` out 1: `sum == 0`.
- `negative` out 1: `sum[WIDTH-1]`.

## Operation
- States:
  - IDLE → RUN on accept.
  - RUN → DONE after digit N−1.
  - DONE → RUN on accept, else → IDLE.
- On accept:
  - Latch `a` into the A register.
  - Latch `b ^ {WIDTH{opcode}}` into the B register.
  - Set the carry register to `opcode` (two's-complement subtract).
  - Clear the digit counter.
- Each RUN cycle:
  - Add A slice k, B slice k and the carry register to form a `DIGIT+1`-bit result.
  - Write the low `DIGIT` bits into result slice k.
  - Update the carry register and increment k.
- At the final digit:
  - Carry-into-MSB is the internal carry of the top slice at bit `DIGIT-1`.
  - `overflow = carry_into_msb ^ carry_out`.
  - `carry = carry_out`.
- On RUN → DONE:
  - Copy the working result to `sum`.
  - Compute `zero` and `negative` from the final `sum`, after saturation if enabled.
- `start` while `busy` is ignored and has no side effects. Operands may change freely after acceptance.
- Reset, including mid-RUN:
  - State goes to IDLE and the counter and working registers clear.
  - `sum`, `carry`, `overflow`, `zero`, `negative`, `done` and `busy` all go to 0.
  - `ready` goes to 1.
  - The aborted operation never produces `done`.
- Note: `zero` resets to 0 even though `sum` is 0. Flags are meaningful only after the first `done`.

## Timing
- Accept edge E0; RUN edges E1…EN.
- At edge EN, outputs update and `done` rises. `done` stays high exactly one cycle.
- Start-to-done latency is N cycles.
- Back-to-back throughput:
  - `start` held high in DONE is accepted at E(N+1).
  - One operation completes every N+1 cycles.
- Outputs are all registered. `ready` and `busy` decode directly from the state register.

## Configuration
- Macro `SERIAL_ADDSUB_SATURATE_EN`.
- When defined, a result with `overflow = 1` is clamped:
  - A non-negative A gives `sum` = `{0,1…1}`.
  - A negative A gives `{1,0…0}`.
  - `overflow` still reports 1 and `carry` is unclamped.
- When undefined, `sum` is the wrapped modulo-2^WIDTH result. No saturation logic is synthesised.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 (N=4) unless noted.
- **Add:** A=100, B=100, op=0 → `sum`=200, `carry`=0, `overflow`=0, `zero`=0, `negative`=0. `done` occurs exactly 4 cycles after acceptance. `ready` is low during those cycles.
- **Overflow:** A=32767, B=1, op=0 → `overflow`=1, `carry`=0. `sum`=0x8000 without the macro, 0x7FFF with `SERIAL_ADDSUB_SATURATE_EN`. Also A=−32768, B=−1 → `sum`=0x7FFF (wrapped) or 0x8000 (saturated), `carry`=1.
- **Subtract:**
  - A=10, B=−125, op=1 → `sum`=135, `carry`=0, `overflow`=0.
  - A=5, B=5, op=1 → `sum`=0, `zero`=1, `carry`=1.
- **Negative sum:** A=−123, B=−6, op=0 → `sum`=0xFF7F (−129), `carry`=1, `overflow`=0, `negative`=1.
- **Handshake:**
  - Pulse `start` again with new operands during RUN → ignored; the first result is unchanged.
  - Hold `start` high across DONE → a second result appears 5 cycles after the first.
  - With DIGIT=16 (N=1), `done` occurs 1 cycle after acceptance.
- **Reset:**
  - Assert `reset` 2 cycles into RUN → all outputs 0 immediately, `ready`=1, no `done` pulse.
  - A subsequent start with A=1, B=2, op=0 → `sum`=3 after 4 cycles.

Source files
------------

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial signed adder/subtractor with carry/overflow/zero/negative flags
// Optional clamp on signed overflow: define SERIAL_ADDSUB_SATURATE_EN.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             opcode,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic [WIDTH-1:0] final_sum;
    logic             creg;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dsum;
    logic             last;
    logic             accept;
    logic             cin_msb;
    logic             ovf_nxt;
    int               idx;

    assign accept = start && ready;
    assign last   = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == S_IDLE) || (state == S_DONE);
        busy  = (state == S_RUN);
    end

    // One digit of the ripple add; carry into the top bit is recovered from the sum bit.
    always_comb begin
        idx      = int'(cnt) * DIGIT;
        a_dig    = areg[idx +: DIGIT];
        b_dig    = breg[idx +: DIGIT];
        dsum     = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, creg};
        cin_msb  = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dsum[DIGIT-1];
        ovf_nxt  = cin_msb ^ dsum[DIGIT];
        work_nxt = work;
        work_nxt[idx +: DIGIT] = dsum[DIGIT-1:0];
    end

    always_comb begin
        final_sum = work_nxt;
`ifdef SERIAL_ADDSUB_SATURATE_EN
        if (ovf_nxt) begin
            final_sum = areg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            areg     <= '0;
            breg     <= '0;
            work     <= '0;
            creg     <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                areg <= a;
                breg <= b ^ {WIDTH{opcode}};
                creg <= opcode;
                cnt  <= '0;
                work <= '0;
            end else if (state == S_RUN) begin
                work <= work_nxt;
                creg <= dsum[DIGIT];
                cnt  <= last ? '0 : cnt + CW'(1);
                if (last) begin
                    done     <= 1'b1;
                    sum      <= final_sum;
                    carry    <= dsum[DIGIT];
                    overflow <= ovf_nxt;
                    zero     <= (final_sum == '0);
                    negative <= final_sum[WIDTH-1];
                end
            end
        end
    end

endmodule
